// File: rtl/mipi_frame_source.sv
// MIPI-side frame source: bursts of incrementing 32-bit words, then a four-phase
// request/acknowledge handshake with the bridge before the next frame.
//
// state   | meaning
// START   | post-reset idle delay before the first frame
// WRITE   | streaming BURST_WORDS words on mipi_wr_en
// REQ     | ft601_req high, waiting for synchronised ack
// ACK_LOW | ft601_req low, waiting for synchronised ack to drop
// GAP     | idle between handshake completion and the next frame
// DONE    | frame budget exhausted, outputs parked at 0 until reset
module mipi_frame_source #(
   parameter int unsigned BURST_WORDS = 1024,
   parameter int unsigned START_DELAY = 32,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter logic [31:0] DATA_SEED   = 32'h0000_0000,
   parameter int unsigned NUM_FRAMES  = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] mipi_wr_data,
   output logic        mipi_wr_en,
   output logic        ft601_req,
   input  logic        ft601_ack
);

   localparam logic [31:0] BURST_LAST  = 32'(BURST_WORDS - 1);
   localparam logic [31:0] START_LOAD  = 32'(START_DELAY);
   localparam logic [31:0] GAP_LOAD    = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] FRAME_LIMIT = 32'(NUM_FRAMES);
   // req stays up long enough for the bridge's own synchroniser to catch it
   localparam logic [1:0]  REQ_MIN_HOLD = 2'd2;

   typedef enum logic [2:0] {
      ST_START,
      ST_WRITE,
      ST_REQ,
      ST_ACK_LOW,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t      state;
   logic        ack_meta;
   logic        ack_s;
   logic [31:0] word_cnt;
   logic [31:0] frame_cnt;
   logic [31:0] tmr;
   logic [31:0] burst_cnt;
   logic [1:0]  req_hold;
   logic        limit_now;
   logic        limit_next;

   assign limit_now  = (FRAME_LIMIT != 32'd0) && (frame_cnt == FRAME_LIMIT);
   assign limit_next = (FRAME_LIMIT != 32'd0) && ((frame_cnt + 32'd1) == FRAME_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= ft601_ack;
         ack_s    <= ack_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_START;
         tmr          <= START_LOAD;
         burst_cnt    <= '0;
         req_hold     <= '0;
         word_cnt     <= DATA_SEED;
         frame_cnt    <= '0;
         mipi_wr_data <= '0;
         mipi_wr_en   <= 1'b0;
         ft601_req    <= 1'b0;
      end else begin
         case (state)
            ST_START: begin
               if (tmr == 32'd0) begin
                  state        <= ST_WRITE;
                  mipi_wr_en   <= 1'b1;
                  mipi_wr_data <= word_cnt;
                  word_cnt     <= word_cnt + 32'd1;
                  burst_cnt    <= BURST_LAST;
               end else begin
                  tmr <= tmr - 32'd1;
               end
            end
            ST_WRITE: begin
               if (burst_cnt == 32'd0) begin
                  state      <= ST_REQ;
                  mipi_wr_en <= 1'b0;
                  ft601_req  <= 1'b1;
                  req_hold   <= REQ_MIN_HOLD;
               end else begin
                  mipi_wr_data <= word_cnt;
                  word_cnt     <= word_cnt + 32'd1;
                  burst_cnt    <= burst_cnt - 32'd1;
               end
            end
            ST_REQ: begin
               if (req_hold != 2'd0) begin
                  req_hold <= req_hold - 2'd1;
               end else if (ack_s) begin
                  state     <= ST_ACK_LOW;
                  ft601_req <= 1'b0;
               end
            end
            ST_ACK_LOW: begin
               if (!ack_s) begin
                  frame_cnt <= frame_cnt + 32'd1;
                  // a zero-length gap is skipped entirely rather than spending a cycle in GAP
                  if (GAP_CYCLES != 0) begin
                     state <= ST_GAP;
                     tmr   <= GAP_LOAD;
                  end else if (limit_next) begin
                     state        <= ST_DONE;
                     mipi_wr_data <= '0;
                  end else begin
                     state        <= ST_WRITE;
                     mipi_wr_en   <= 1'b1;
                     mipi_wr_data <= word_cnt;
                     word_cnt     <= word_cnt + 32'd1;
                     burst_cnt    <= BURST_LAST;
                  end
               end
            end
            ST_GAP: begin
               if (tmr != 32'd0) begin
                  tmr <= tmr - 32'd1;
               end else if (limit_now) begin
                  state        <= ST_DONE;
                  mipi_wr_data <= '0;
               end else begin
                  state        <= ST_WRITE;
                  mipi_wr_en   <= 1'b1;
                  mipi_wr_data <= word_cnt;
                  word_cnt     <= word_cnt + 32'd1;
                  burst_cnt    <= BURST_LAST;
               end
            end
            ST_DONE: begin
               mipi_wr_en   <= 1'b0;
               ft601_req    <= 1'b0;
               mipi_wr_data <= '0;
            end
            default: begin
               state <= ST_START;
               tmr   <= START_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_frame_source.sv
// Bench for mipi_frame_source: several parameterisations, each exercised with
// checkpoint tables, hand-written handshake sequences and a random ack responder.
module tb_mipi_frame_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // defaults: B=1024, start 32, gap 16, seed 0, unlimited; ack tied low
   logic        rst_def = 1'b0;
   logic [31:0] d_data;
   logic        d_en, d_req;
   logic        d_ack = 1'b0;
   mipi_frame_source u_def (
      .clk(clk), .reset_n(rst_def), .mipi_wr_data(d_data),
      .mipi_wr_en(d_en), .ft601_req(d_req), .ft601_ack(d_ack));

   localparam int HS_B = 4, HS_SD = 3, HS_G = 16;
   logic        rst_hs = 1'b0;
   logic [31:0] h_data;
   logic        h_en, h_req;
   logic        h_ack = 1'b0;
   mipi_frame_source #(.BURST_WORDS(HS_B), .START_DELAY(HS_SD), .GAP_CYCLES(HS_G),
                       .DATA_SEED(32'h0), .NUM_FRAMES(0)) u_hs (
      .clk(clk), .reset_n(rst_hs), .mipi_wr_data(h_data),
      .mipi_wr_en(h_en), .ft601_req(h_req), .ft601_ack(h_ack));

   logic        rst_wr = 1'b0;
   logic [31:0] w_data;
   logic        w_en, w_req;
   logic        w_ack = 1'b0;
   mipi_frame_source #(.BURST_WORDS(4), .START_DELAY(0), .GAP_CYCLES(0),
                       .DATA_SEED(32'hFFFF_FFFE), .NUM_FRAMES(0)) u_wr (
      .clk(clk), .reset_n(rst_wr), .mipi_wr_data(w_data),
      .mipi_wr_en(w_en), .ft601_req(w_req), .ft601_ack(w_ack));

   localparam logic [31:0] LIM_SEED = 32'h0;
   logic        rst_lim = 1'b0;
   logic [31:0] l_data;
   logic        l_en, l_req;
   logic        l_ack = 1'b0;
   mipi_frame_source #(.BURST_WORDS(8), .START_DELAY(2), .GAP_CYCLES(3),
                       .DATA_SEED(LIM_SEED), .NUM_FRAMES(2)) u_lim (
      .clk(clk), .reset_n(rst_lim), .mipi_wr_data(l_data),
      .mipi_wr_en(l_en), .ft601_req(l_req), .ft601_ack(l_ack));

   localparam int RS_SD = 4;
   localparam logic [31:0] RS_SEED = 32'h0000_0100;
   logic        rst_rs = 1'b0;
   logic [31:0] r_data;
   logic        r_en, r_req;
   logic        r_ack = 1'b0;
   mipi_frame_source #(.BURST_WORDS(8), .START_DELAY(RS_SD), .GAP_CYCLES(2),
                       .DATA_SEED(RS_SEED), .NUM_FRAMES(0)) u_rs (
      .clk(clk), .reset_n(rst_rs), .mipi_wr_data(r_data),
      .mipi_wr_en(r_en), .ft601_req(r_req), .ft601_ack(r_ack));

   // random-latency four-phase responder for the frame-limited instance
   initial begin
      forever begin
         @(negedge clk);
         if (l_req && !l_ack) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            l_ack = 1'b1;
         end else if (!l_req && l_ack) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            l_ack = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          edge_n;
      logic        en;
      logic [31:0] data;
      logic        req;
   } chk_t;

   chk_t        tbl[7];
   logic [31:0] wrap_exp[4];
   int          n, hi, strobes, pulses, late_bad, cnt_en, cnt_req;
   logic [31:0] exp_w;
   logic        contig, prev_req;

   initial begin
      tbl[0] = '{1,    1'b0, 32'd0,    1'b0};
      tbl[1] = '{32,   1'b0, 32'd0,    1'b0};
      tbl[2] = '{33,   1'b1, 32'd0,    1'b0};
      tbl[3] = '{34,   1'b1, 32'd1,    1'b0};
      tbl[4] = '{1056, 1'b1, 32'd1023, 1'b0};
      tbl[5] = '{1057, 1'b0, 32'd1023, 1'b1};
      tbl[6] = '{1200, 1'b0, 32'd1023, 1'b1};
      wrap_exp[0] = 32'hFFFF_FFFE;
      wrap_exp[1] = 32'hFFFF_FFFF;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0001;

      repeat (3) @(negedge clk);
      chk("rst_en",   d_en,   1'b0);
      chk("rst_data", d_data, 32'd0);
      chk("rst_req",  d_req,  1'b0);

      // default frame: checkpoints plus contiguity over the whole burst
      rst_def = 1'b1;
      exp_w = 32'd0; strobes = 0; contig = 1'b1;
      for (int e = 1; e <= 1200; e++) begin
         @(negedge clk);
         for (int i = 0; i < 7; i++) begin
            if (tbl[i].edge_n == e) begin
               chk("def_en",   d_en,   tbl[i].en);
               chk("def_data", d_data, tbl[i].data);
               chk("def_req",  d_req,  tbl[i].req);
            end
         end
         if (d_en) begin
            if (d_data !== exp_w) contig = 1'b0;
            exp_w++;
            strobes++;
         end
      end
      chk("def_strobes", strobes, 1024);
      chk("def_contig",  contig,  1'b1);

      // handshake timing
      rst_hs = 1'b1;
      exp_w = 32'd0; strobes = 0; n = 0;
      while (!h_req && n < 200) begin
         @(negedge clk); n++;
         if (h_en) begin chk("hs_word", h_data, exp_w); exp_w++; strobes++; end
      end
      chk("hs_req_seen", h_req, 1'b1);
      chk("hs_f1_strobes", strobes, HS_B);
      repeat (5) @(negedge clk);
      h_ack = 1'b1;
      n = 0;
      while (h_req && n < 20) begin @(negedge clk); n++; end
      chk("hs_req_fall", n, 3);
      repeat (3) @(negedge clk);
      h_ack = 1'b0;
      n = 0;
      while (!h_en && n < 100) begin @(negedge clk); n++; end
      chk("hs_gap", n, HS_G + 3);
      chk("hs_f2_first", h_data, 32'd4);

      // stale ack: raised during frame 2, well before REQ
      h_ack = 1'b1;
      exp_w = 32'd5; n = 0;
      while (!h_req && n < 50) begin
         @(negedge clk); n++;
         if (h_en) begin chk("stale_word", h_data, exp_w); exp_w++; end
      end
      chk("stale_req_seen", h_req, 1'b1);
      hi = 1; n = 0;
      while (h_req && n < 50) begin
         @(negedge clk); n++;
         if (h_req) hi++;
      end
      chk("stale_req_width", hi, 3);
      cnt_en = 0; cnt_req = 0;
      repeat (40) begin
         @(negedge clk);
         if (h_en) cnt_en++;
         if (h_req) cnt_req++;
      end
      chk("stale_hold_en", cnt_en, 0);
      chk("stale_hold_req", cnt_req, 0);
      h_ack = 1'b0;
      n = 0;
      while (!h_en && n < 100) begin @(negedge clk); n++; end
      chk("stale_gap", n, HS_G + 3);
      chk("stale_f3_first", h_data, 32'd8);

      // counter wrap, zero start delay
      rst_wr = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_en", w_en, 1'b1);
         chk("wrap_data", w_data, wrap_exp[i]);
         @(negedge clk);
      end
      chk("wrap_end_en", w_en, 1'b0);
      chk("wrap_end_req", w_req, 1'b1);
      chk("wrap_hold_data", w_data, 32'h1);

      // frame limit with randomised ack latency
      rst_lim = 1'b1;
      strobes = 0; pulses = 0; late_bad = 0; prev_req = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (l_en) begin
            chk("lim_word", l_data, LIM_SEED + 32'(strobes));
            strobes++;
         end
         if (l_req && !prev_req) pulses++;
         prev_req = l_req;
         if (c >= 500 && (l_en || l_req || l_data != 32'd0)) late_bad++;
      end
      chk("lim_strobes", strobes, 16);
      chk("lim_pulses", pulses, 2);
      chk("lim_done_quiet", late_bad, 0);

      // reset during word 5
      rst_rs = 1'b1;
      n = 0;
      while (!(r_en && r_data == RS_SEED + 32'd4) && n < 100) begin @(negedge clk); n++; end
      chk("rs_word5_seen", r_en, 1'b1);
      rst_rs = 1'b0;
      #1;
      chk("rs_async_en", r_en, 1'b0);
      chk("rs_async_data", r_data, 32'd0);
      chk("rs_async_req", r_req, 1'b0);
      repeat (2) @(negedge clk);
      rst_rs = 1'b1;
      n = 0;
      while (!r_en && n < 100) begin @(negedge clk); n++; end
      chk("rs_restart_edge", n, RS_SD + 1);
      chk("rs_restart_data", r_data, RS_SEED);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mipi_frame_source.md
Name: mipi_frame_source

Overview:
Synthesisable-style behavioural stimulus source that stands in for the MIPI receive path in the FT601 bridge bench. It emits bursts ("frames") of 32-bit incrementing words on a write strobe toward the bridge's MIPI-side FIFO. After each frame it raises a four-phase request so the bridge drains the frame to the FT601, then idles and repeats. It runs in the MIPI clock domain (90 MHz in the system bench).

Parameters:
BURST_WORDS, 1024, words written per frame (>=1)
START_DELAY, 32, idle cycles after reset release before the first write
GAP_CYCLES, 16, idle cycles between handshake completion and the next frame
DATA_SEED, 32'h0000_0000, value of the first word after reset
NUM_FRAMES, 0, frames to send before stopping permanently; 0 = unlimited

Ports:
clk  input  1  MIPI-domain clock; all logic is rising-edge
reset_n  input  1  asynchronous active-low reset
mipi_wr_data  output  32  frame data word, valid when mipi_wr_en=1
mipi_wr_en  output  1  write strobe, one word per high cycle
ft601_req  output  1  frame-ready request to the bridge (four-phase)
ft601_ack  input  1  bridge acknowledge; may be asynchronous to clk

Behaviour:
- One clock, reset asynchronous active-low. While reset_n=0: mipi_wr_en=0, mipi_wr_data=0, ft601_req=0, word counter=DATA_SEED, frame counter=0, state=START.
- All outputs are registered (driven from flops, no combinational paths from ft601_ack).
- ft601_ack passes through a 2-flop synchroniser (ack_s); the FSM uses only ack_s. Synchroniser flops reset to 0.
- FSM states:
  - START: count START_DELAY cycles after reset release, then go to WRITE. The first mipi_wr_en=1 appears on the rising edge START_DELAY+1 after reset_n rises.
  - WRITE: mipi_wr_en=1 for exactly BURST_WORDS consecutive cycles with no bubbles. mipi_wr_data = word counter, which increments by 1 per word and wraps 32'hFFFF_FFFF -> 0. The counter continues across frames and is never reset between frames. After the last word, mipi_wr_en=0 and the FSM goes to REQ.
  - REQ: ft601_req=1, asserted on the cycle following the last word. Hold it until ack_s=1, deassert it on the next edge, then go to ACK_LOW.
  - ACK_LOW: ft601_req=0. Wait for ack_s=0, then increment the frame counter and go to GAP.
  - GAP: count GAP_CYCLES idle cycles. If NUM_FRAMES!=0 and frame counter==NUM_FRAMES, go to DONE; otherwise go to WRITE.
  - DONE: all outputs 0 forever, until reset.
- mipi_wr_data holds its last written value when mipi_wr_en=0; do not clear it.
- If ack_s is already 1 on entry to REQ (stale ack), still assert req for at least one cycle, then follow the normal sequence.
- No backpressure: the bridge FIFO must absorb BURST_WORDS words. No full signal exists.
- Reset asserted mid-frame or mid-handshake forces the reset values immediately. Restart begins at START with the counter back at DATA_SEED.
- GAP_CYCLES=0 or START_DELAY=0 means zero idle cycles in that state (the state is exited on its entry cycle).

Test Plan:
- Reset release, defaults, ack tied 0 -> first mipi_wr_en at edge 33. Data runs 0..1023 contiguously. ft601_req=1 from the edge after word 1023 and stays high indefinitely.
- BURST_WORDS=4, ack raised 5 cycles after req and lowered 3 cycles after req falls -> req falls 3 cycles after ack rises (2 sync + 1). Second frame carries data 4..7 and starts GAP_CYCLES+3 cycles after ack falls.
- DATA_SEED=32'hFFFF_FFFE, BURST_WORDS=4 -> data FFFF_FFFE, FFFF_FFFF, 0, 1.
- NUM_FRAMES=2, BURST_WORDS=8, automatic ack responder -> exactly 16 write strobes (data 0..15), two req pulses, then all outputs stay 0.
- reset_n pulsed low during word 5 of a frame -> all outputs 0 within the same time step. After release, the first word is DATA_SEED after START_DELAY+1 edges.
- Stale ack=1 held before REQ -> req high for exactly 3 cycles (1 minimum plus sync latency). FSM then waits in ACK_LOW until ack drops, and sends no new frame until then.
